// File: rtl/ma_stage.sv
// Memory-access stage: drives the req/ack data port, stalls on wait states,
// and feeds the MA/WB pipeline register plus the EX forwarding path.
module ma_stage #(
  parameter int WIDTH     = 32,
  parameter int WB_WIDTH  = 2,
  parameter int MA_WIDTH  = 2,
  parameter int RDS_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WB_WIDTH-1:0]  i_WB_Ctrl,
  input  logic [MA_WIDTH-1:0]  i_MEM_Ctrl,
  input  logic [WIDTH-1:0]     i_ALU_rslt,
  input  logic [WIDTH-1:0]     i_Rs2_val,
  input  logic [RDS_WIDTH-1:0] i_Rds_addr,
  input  logic [WIDTH-1:0]     i_PC,
  input  logic                 i_Fwrd_Store,
  input  logic [WIDTH-1:0]     i_Data_From_WB,
  input  logic                 i_MAWB_flush,
  input  logic                 i_MAWB_stall,
  output logic                 o_Mem_req,
  output logic                 o_Mem_we,
  output logic [WIDTH-1:0]     o_Mem_addr,
  output logic [WIDTH-1:0]     o_Mem_wdata,
  input  logic                 i_Mem_ack,
  input  logic [WIDTH-1:0]     i_Mem_rdata,
  output logic                 o_Stall_Req,
  output logic                 o_Misaligned,
  output logic [WIDTH-1:0]     o_Data_To_Fwrd,
  output logic [WB_WIDTH-1:0]  o_MAWB_WB,
  output logic [WIDTH-1:0]     o_MAWB_Rslt,
  output logic [RDS_WIDTH-1:0] o_MAWB_Rds_addr,
  output logic [WIDTH-1:0]     o_MAWB_PC
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cap_addr_q, cap_addr_d;
  logic [WIDTH-1:0]     cap_wdata_q, cap_wdata_d;
  logic                 cap_we_q, cap_we_d;
  logic [WIDTH-1:0]     buf_q, buf_d;
  logic [WB_WIDTH-1:0]  wb_q, wb_d;
  logic [WIDTH-1:0]     rslt_q, rslt_d;
  logic [RDS_WIDTH-1:0] rds_q, rds_d;
  logic [WIDTH-1:0]     pc_q, pc_d;

  logic                 op;
  logic                 is_st;
  logic                 mis;
  logic [WIDTH-1:0]     st_data;
  logic                 req;
  logic                 we;
  logic [WIDTH-1:0]     addr;
  logic [WIDTH-1:0]     wdata;
  logic                 stall;
  logic                 mis_hit;
  logic [WIDTH-1:0]     res;
  logic [WB_WIDTH-1:0]  wb_eff;

  always_comb begin
    op          = |i_MEM_Ctrl;
    is_st       = i_MEM_Ctrl[1];
    mis         = op & (|i_ALU_rslt[1:0]);
    st_data     = i_Fwrd_Store ? i_Data_From_WB : i_Rs2_val;
    state_d     = state_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_we_d    = cap_we_q;
    buf_d       = buf_q;
    req         = 1'b0;
    we          = 1'b0;
    addr        = i_ALU_rslt;
    wdata       = st_data;
    stall       = 1'b0;
    mis_hit     = 1'b0;
    res         = i_ALU_rslt;

    unique case (state_q)
      S_IDLE: begin
        if (op && mis) begin
          mis_hit = 1'b1;
        end else if (op) begin
          req         = 1'b1;
          we          = is_st;
          cap_addr_d  = i_ALU_rslt;
          cap_wdata_d = st_data;
          cap_we_d    = is_st;
          if (i_Mem_ack) begin
            if (!is_st) res = i_Mem_rdata;
            if (i_MAWB_stall) begin
              state_d = S_DONE;
              buf_d   = i_Mem_rdata;
            end
          end else begin
            stall   = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req   = 1'b1;
        we    = cap_we_q;
        addr  = cap_addr_q;
        wdata = cap_wdata_q;
        if (i_Mem_ack) begin
          if (!cap_we_q) res = i_Mem_rdata;
          buf_d   = i_Mem_rdata;
          state_d = i_MAWB_stall ? S_DONE : S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      S_DONE: begin
        if (!cap_we_q) res = buf_q;
        if (!i_MAWB_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset masks every handshake output even mid-access.
    o_Mem_req    = req & ~reset;
    o_Mem_we     = we & req & ~reset;
    o_Mem_addr   = addr;
    o_Mem_wdata  = wdata;
    o_Stall_Req  = stall & ~reset;
    o_Misaligned = mis_hit & ~reset;

    wb_eff = mis_hit ? '0 : i_WB_Ctrl;

    wb_d   = wb_q;
    rslt_d = rslt_q;
    rds_d  = rds_q;
    pc_d   = pc_q;
    if (i_MAWB_flush || (!i_MAWB_stall && o_Stall_Req)) begin
      wb_d   = '0;
      rslt_d = '0;
      rds_d  = '0;
      pc_d   = '0;
    end else if (!i_MAWB_stall) begin
      wb_d   = wb_eff;
      rslt_d = res;
      rds_d  = i_Rds_addr;
      pc_d   = i_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_we_q    <= 1'b0;
      buf_q       <= '0;
      wb_q        <= '0;
      rslt_q      <= '0;
      rds_q       <= '0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_we_q    <= cap_we_d;
      buf_q       <= buf_d;
      wb_q        <= wb_d;
      rslt_q      <= rslt_d;
      rds_q       <= rds_d;
      pc_q        <= pc_d;
    end
  end

  assign o_Data_To_Fwrd  = i_ALU_rslt;
  assign o_MAWB_WB       = wb_q;
  assign o_MAWB_Rslt     = rslt_q;
  assign o_MAWB_Rds_addr = rds_q;
  assign o_MAWB_PC       = pc_q;

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage with a scoreboard of expected MA/WB contents.
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  i_WB_Ctrl;
  logic [1:0]  i_MEM_Ctrl;
  logic [31:0] i_ALU_rslt;
  logic [31:0] i_Rs2_val;
  logic [4:0]  i_Rds_addr;
  logic [31:0] i_PC;
  logic        i_Fwrd_Store;
  logic [31:0] i_Data_From_WB;
  logic        i_MAWB_flush;
  logic        i_MAWB_stall;
  logic        o_Mem_req;
  logic        o_Mem_we;
  logic [31:0] o_Mem_addr;
  logic [31:0] o_Mem_wdata;
  logic        i_Mem_ack;
  logic [31:0] i_Mem_rdata;
  logic        o_Stall_Req;
  logic        o_Misaligned;
  logic [31:0] o_Data_To_Fwrd;
  logic [1:0]  o_MAWB_WB;
  logic [31:0] o_MAWB_Rslt;
  logic [4:0]  o_MAWB_Rds_addr;
  logic [31:0] o_MAWB_PC;

  always #5 clk = ~clk;

  ma_stage dut (
    .clk(clk),
    .reset(reset),
    .i_WB_Ctrl(i_WB_Ctrl),
    .i_MEM_Ctrl(i_MEM_Ctrl),
    .i_ALU_rslt(i_ALU_rslt),
    .i_Rs2_val(i_Rs2_val),
    .i_Rds_addr(i_Rds_addr),
    .i_PC(i_PC),
    .i_Fwrd_Store(i_Fwrd_Store),
    .i_Data_From_WB(i_Data_From_WB),
    .i_MAWB_flush(i_MAWB_flush),
    .i_MAWB_stall(i_MAWB_stall),
    .o_Mem_req(o_Mem_req),
    .o_Mem_we(o_Mem_we),
    .o_Mem_addr(o_Mem_addr),
    .o_Mem_wdata(o_Mem_wdata),
    .i_Mem_ack(i_Mem_ack),
    .i_Mem_rdata(i_Mem_rdata),
    .o_Stall_Req(o_Stall_Req),
    .o_Misaligned(o_Misaligned),
    .o_Data_To_Fwrd(o_Data_To_Fwrd),
    .o_MAWB_WB(o_MAWB_WB),
    .o_MAWB_Rslt(o_MAWB_Rslt),
    .o_MAWB_Rds_addr(o_MAWB_Rds_addr),
    .o_MAWB_PC(o_MAWB_PC)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rslt;
    logic [4:0]  rds;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  ent_t mdl = '{wb: 2'b0, rslt: 32'h0, rds: 5'h0, pc: 32'h0};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, push expected MA/WB, pop after edge.
  task automatic cyc(input string tag, input bit e_req,
                     input logic [31:0] e_addr, input bit e_we,
                     input logic [31:0] e_wd, input bit e_stall,
                     input bit e_mis, input logic [31:0] e_res);
    ent_t n;
    ent_t e;
    #2;
    chk({tag, ".req"}, 32'(o_Mem_req), 32'(e_req));
    chk({tag, ".stall"}, 32'(o_Stall_Req), 32'(e_stall));
    chk({tag, ".mis"}, 32'(o_Misaligned), 32'(e_mis));
    chk({tag, ".fwd"}, o_Data_To_Fwrd, i_ALU_rslt);
    if (e_req) begin
      chk({tag, ".addr"}, o_Mem_addr, e_addr);
      chk({tag, ".we"}, 32'(o_Mem_we), 32'(e_we));
      chk({tag, ".wdata"}, o_Mem_wdata, e_wd);
    end
    n = mdl;
    if (reset || i_MAWB_flush || (!i_MAWB_stall && e_stall))
      n = '{wb: 2'b0, rslt: 32'h0, rds: 5'h0, pc: 32'h0};
    else if (!i_MAWB_stall)
      n = '{wb: (e_mis ? 2'b00 : i_WB_Ctrl), rslt: e_res,
            rds: i_Rds_addr, pc: i_PC};
    mdl = n;
    q.push_back(n);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".mawb_wb"}, 32'(o_MAWB_WB), 32'(e.wb));
    chk({tag, ".mawb_rslt"}, o_MAWB_Rslt, e.rslt);
    chk({tag, ".mawb_rds"}, 32'(o_MAWB_Rds_addr), 32'(e.rds));
    chk({tag, ".mawb_pc"}, o_MAWB_PC, e.pc);
  endtask

  initial begin
    reset = 1'b1;
    i_WB_Ctrl = 2'b01;
    i_MEM_Ctrl = 2'b01;
    i_ALU_rslt = 32'h100;
    i_Rs2_val = 32'h77;
    i_Rds_addr = 5'd1;
    i_PC = 32'h3c;
    i_Fwrd_Store = 1'b0;
    i_Data_From_WB = 32'h0;
    i_MAWB_flush = 1'b0;
    i_MAWB_stall = 1'b0;
    i_Mem_ack = 1'b0;
    i_Mem_rdata = 32'h0;
    @(posedge clk);
    #1;
    cyc("rst0", 0, 0, 0, 0, 0, 0, 0);
    cyc("rst1", 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    i_MEM_Ctrl = 2'b00;
    i_ALU_rslt = 32'h1234;
    i_Rds_addr = 5'd3;
    i_PC = 32'h40;
    cyc("alu", 0, 0, 0, 0, 0, 0, 32'h1234);

    i_MEM_Ctrl = 2'b01;
    i_ALU_rslt = 32'h100;
    i_Rds_addr = 5'd5;
    i_PC = 32'h44;
    cyc("ld_w1", 1, 32'h100, 0, 32'h77, 1, 0, 0);
    i_ALU_rslt = 32'h999;
    cyc("ld_w2", 1, 32'h100, 0, 32'h77, 1, 0, 0);
    i_ALU_rslt = 32'h100;
    cyc("ld_w3", 1, 32'h100, 0, 32'h77, 1, 0, 0);
    i_Mem_ack = 1'b1;
    i_Mem_rdata = 32'hDEADBEEF;
    cyc("ld_ack", 1, 32'h100, 0, 32'h77, 0, 0, 32'hDEADBEEF);

    i_MEM_Ctrl = 2'b00;
    i_Mem_ack = 1'b0;
    i_Mem_rdata = 32'h0;
    i_ALU_rslt = 32'h55;
    i_Rds_addr = 5'd6;
    i_PC = 32'h48;
    cyc("alu2", 0, 0, 0, 0, 0, 0, 32'h55);

    i_WB_Ctrl = 2'b00;
    i_MEM_Ctrl = 2'b10;
    i_ALU_rslt = 32'h200;
    i_Rs2_val = 32'h1111;
    i_Fwrd_Store = 1'b1;
    i_Data_From_WB = 32'hCAFE;
    i_Mem_ack = 1'b1;
    i_Rds_addr = 5'd0;
    i_PC = 32'h4c;
    cyc("st", 1, 32'h200, 1, 32'hCAFE, 0, 0, 32'h200);
    i_Fwrd_Store = 1'b0;
    i_MEM_Ctrl = 2'b11;
    i_ALU_rslt = 32'h204;
    i_Rs2_val = 32'h2222;
    cyc("st11", 1, 32'h204, 1, 32'h2222, 0, 0, 32'h204);

    i_WB_Ctrl = 2'b01;
    i_MEM_Ctrl = 2'b01;
    i_ALU_rslt = 32'h300;
    i_Mem_rdata = 32'hA5A5A5A5;
    i_MAWB_stall = 1'b1;
    i_Rds_addr = 5'd7;
    i_PC = 32'h50;
    cyc("ldh1", 1, 32'h300, 0, 32'h2222, 0, 0, 32'hA5A5A5A5);
    i_Mem_ack = 1'b0;
    i_Mem_rdata = 32'h0;
    cyc("ldh2", 0, 0, 0, 0, 0, 0, 0);
    i_MAWB_stall = 1'b0;
    cyc("ldh3", 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5);

    i_ALU_rslt = 32'h102;
    i_Rds_addr = 5'd8;
    i_PC = 32'h54;
    cyc("mis", 0, 0, 0, 0, 0, 1, 32'h102);

    i_ALU_rslt = 32'h400;
    i_Rds_addr = 5'd9;
    i_PC = 32'h58;
    cyc("rw1", 1, 32'h400, 0, 32'h2222, 1, 0, 0);
    reset = 1'b1;
    cyc("rw_rst", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    i_MEM_Ctrl = 2'b00;
    i_ALU_rslt = 32'h0;
    cyc("rw_idle", 0, 0, 0, 0, 0, 0, 0);
    i_MEM_Ctrl = 2'b01;
    i_ALU_rslt = 32'h404;
    i_Rds_addr = 5'd10;
    i_PC = 32'h5c;
    cyc("rl1", 1, 32'h404, 0, 32'h2222, 1, 0, 0);
    i_Mem_ack = 1'b1;
    i_Mem_rdata = 32'h12345678;
    cyc("rl2", 1, 32'h404, 0, 32'h2222, 0, 0, 32'h12345678);

    i_Mem_ack = 1'b0;
    i_ALU_rslt = 32'h500;
    i_MAWB_flush = 1'b1;
    i_Rds_addr = 5'd11;
    i_PC = 32'h60;
    cyc("fl1", 1, 32'h500, 0, 32'h2222, 1, 0, 0);
    i_Mem_ack = 1'b1;
    i_Mem_rdata = 32'hBAD;
    cyc("fl2", 1, 32'h500, 0, 32'h2222, 0, 0, 32'hBAD);
    i_MAWB_flush = 1'b0;
    i_MEM_Ctrl = 2'b00;
    i_Mem_ack = 1'b0;
    i_ALU_rslt = 32'h66;
    cyc("fl3", 0, 0, 0, 0, 0, 0, 32'h66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
